// File: rtl/ram_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the shared 512x16 RAM.
// Each access runs IDLE -> SETUP -> STROBE -> RELEASE, so address and write data bracket the write edge.
module ram_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ena,
    output logic              mem_read,
    output logic              mem_write,
    inout  wire  [DATA_W-1:0] mem_data
);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

    state_t            state, state_nx;
    logic              grant_nx, last_grant, grant_id, lat_we;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata, wdata_q;
    logic              drive_en;

    // The bus is only ever driven from registers, and only for writes.
    assign mem_data = drive_en ? wdata_q : 'z;

    always_comb begin
        state_nx  = state;
        grant_nx  = last_grant;
        case (state)
            IDLE: begin
                if (p0_req || p1_req) begin
                    state_nx = SETUP;
                    if (p0_req && p1_req) grant_nx = ~last_grant;
                    else                  grant_nx = p1_req;
                end
            end
            SETUP:   state_nx = STROBE;
            STROBE:  state_nx = RELEASE;
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        sel_we    = grant_nx ? p1_we    : p0_we;
        sel_addr  = grant_nx ? p1_addr  : p0_addr;
        sel_wdata = grant_nx ? p1_wdata : p0_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            lat_we     <= 1'b0;
            wdata_q    <= '0;
            drive_en   <= 1'b0;
            mem_addr   <= '0;
            mem_ena    <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            state  <= state_nx;
            busy   <= (state_nx != IDLE);
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_nx == SETUP) begin
                        grant_id   <= grant_nx;
                        last_grant <= grant_nx;
                        lat_we     <= sel_we;
                        mem_addr   <= sel_addr;
                        wdata_q    <= sel_wdata;
                        drive_en   <= sel_we;
                        mem_ena    <= 1'b1;
                    end
                end
                SETUP: begin
                    mem_read  <= ~lat_we;
                    mem_write <= lat_we;
                end
                STROBE: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    if (!lat_we) begin
                        if (grant_id) p1_rdata <= mem_data;
                        else          p0_rdata <= mem_data;
                    end
                    p0_ack <= ~grant_id;
                    p1_ack <= grant_id;
                end
                RELEASE: begin
                    // Address, enable and write data held through here for write hold time.
                    mem_ena  <= 1'b0;
                    drive_en <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 512x16 RAM on the shared bus.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [8:0]  p0_addr, p1_addr;
    logic [15:0] p0_wdata, p1_wdata;
    logic        p0_ack, p1_ack, busy, mem_ena, mem_read, mem_write;
    logic [15:0] p0_rdata, p1_rdata;
    logic [8:0]  mem_addr;
    wire  [15:0] mem_data;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] ram [0:511];
    logic        pre_stb = 1'b0;
    logic [8:0]  pre_addr = '0;
    logic [15:0] pre_data = '0;

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .busy(busy), .mem_addr(mem_addr), .mem_ena(mem_ena),
        .mem_read(mem_read), .mem_write(mem_write), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    assign mem_data = (mem_ena && mem_read) ? ram[mem_addr] : 'z;

    always @(posedge mem_write or posedge pre_stb) begin
        if (pre_stb)      ram[pre_addr] = pre_data;
        else if (mem_ena) ram[mem_addr] = mem_data;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [8:0] a, input logic [15:0] d);
        pre_addr = a;
        pre_data = d;
        pre_stb  = 1'b1;
        #1;
        pre_stb  = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        step(); step();
        rst = 1'b0;
        n_vec++;
        if ({busy, mem_ena, mem_read, mem_write, p0_ack, p1_ack} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 000000", {busy, mem_ena, mem_read, mem_write, p0_ack, p1_ack});
        end
        n_vec++;
        if (mem_addr !== 9'h0 || p0_rdata !== 16'h0 || p1_rdata !== 16'h0) begin
            n_err++;
            $display("FAIL reset_data: got addr %h r0 %h r1 %h want all 0", mem_addr, p0_rdata, p1_rdata);
        end
    endtask

    task automatic test_p0_read;
        preload(9'h010, 16'hBEEF);
        p0_req = 1; p0_we = 0; p0_addr = 9'h010;
        step();
        n_vec++;
        if ({busy, mem_ena, mem_read, mem_write} !== 4'b1100 || mem_addr !== 9'h010) begin
            n_err++;
            $display("FAIL rd_setup: got b/e/r/w %b addr %h want 1100 010", {busy, mem_ena, mem_read, mem_write}, mem_addr);
        end
        p0_addr = 9'h0AA;
        step();
        n_vec++;
        if ({mem_read, mem_write, p0_ack} !== 3'b100 || mem_addr !== 9'h010) begin
            n_err++;
            $display("FAIL rd_strobe: got r/w/ack %b addr %h want 100 010", {mem_read, mem_write, p0_ack}, mem_addr);
        end
        step();
        n_vec++;
        if ({mem_read, p0_ack, p1_ack} !== 3'b010 || p0_rdata !== 16'hBEEF) begin
            n_err++;
            $display("FAIL rd_release: got r/a0/a1 %b rdata %h want 010 beef", {mem_read, p0_ack, p1_ack}, p0_rdata);
        end
        p0_req = 0;
        step();
        n_vec++;
        if ({busy, mem_ena, p0_ack} !== 3'b000 || p0_rdata !== 16'hBEEF) begin
            n_err++;
            $display("FAIL rd_idle: got b/e/ack %b rdata %h want 000 beef", {busy, mem_ena, p0_ack}, p0_rdata);
        end
    endtask

    task automatic test_write_then_read;
        p1_req = 1; p1_we = 1; p1_addr = 9'h1FF; p1_wdata = 16'h1234;
        step();
        p1_wdata = 16'hFFFF;
        n_vec++;
        if (mem_data !== 16'h1234 || mem_write !== 1'b0 || mem_ena !== 1'b1) begin
            n_err++;
            $display("FAIL wr_setup: got data %h w %b e %b want 1234 0 1", mem_data, mem_write, mem_ena);
        end
        step();
        n_vec++;
        if (mem_data !== 16'h1234 || mem_write !== 1'b1 || mem_read !== 1'b0) begin
            n_err++;
            $display("FAIL wr_strobe: got data %h w %b r %b want 1234 1 0", mem_data, mem_write, mem_read);
        end
        step();
        n_vec++;
        if (mem_data !== 16'h1234 || mem_write !== 1'b0 || mem_ena !== 1'b1 || mem_addr !== 9'h1FF || p1_ack !== 1'b1) begin
            n_err++;
            $display("FAIL wr_release: got data %h w %b e %b addr %h ack %b want 1234 0 1 1ff 1",
                     mem_data, mem_write, mem_ena, mem_addr, p1_ack);
        end
        p1_req = 0;
        step();
        n_vec++;
        if (ram[9'h1FF] !== 16'h1234) begin
            n_err++;
            $display("FAIL wr_ram: got %h want 1234", ram[9'h1FF]);
        end
        p0_req = 1; p0_we = 0; p0_addr = 9'h1FF;
        step(); step(); step();
        n_vec++;
        if (p0_ack !== 1'b1 || p0_rdata !== 16'h1234 || p1_rdata !== 16'h0) begin
            n_err++;
            $display("FAIL wr_readback: got ack %b r0 %h r1 %h want 1 1234 0", p0_ack, p0_rdata, p1_rdata);
        end
        p0_req = 0;
        step();
    endtask

    task automatic test_contention;
        logic [15:0] exp0, exp1;
        preload(9'h031, 16'hA0A0);
        preload(9'h042, 16'hB1B1);
        rst = 1;
        step();
        rst = 0;
        p0_req = 1; p0_we = 0; p0_addr = 9'h031;
        p1_req = 1; p1_we = 0; p1_addr = 9'h042;
        exp0 = 16'hBEEF;
        exp1 = 16'h0;
        n_vec++;
        if (p0_rdata !== 16'h0) begin
            n_err++;
            $display("FAIL cont_rst_rdata: got %h want 0", p0_rdata);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            n_vec++;
            if (busy !== 1'b1 || mem_addr !== ((k % 2 == 0) ? 9'h031 : 9'h042)) begin
                n_err++;
                $display("FAIL cont_grant%0d: got busy %b addr %h want 1 %h", k, busy, mem_addr,
                         (k % 2 == 0) ? 9'h031 : 9'h042);
            end
            step(); step();
            if (k % 2 == 0) exp0 = 16'hA0A0;
            else            exp1 = 16'hB1B1;
            n_vec++;
            if (p0_ack !== (k % 2 == 0) || p1_ack !== (k % 2 == 1) || p0_rdata !== exp0 || p1_rdata !== exp1) begin
                n_err++;
                $display("FAIL cont_ack%0d: got a0 %b a1 %b r0 %h r1 %h want a0 %b r0 %h r1 %h",
                         k, p0_ack, p1_ack, p0_rdata, p1_rdata, (k % 2 == 0), exp0, exp1);
            end
            if (k == 3) begin
                p0_req = 0;
                p1_req = 0;
            end
            step();
            n_vec++;
            if (busy !== 1'b0 || p0_ack !== 1'b0 || p1_ack !== 1'b0) begin
                n_err++;
                $display("FAIL cont_idle%0d: got busy %b a0 %b a1 %b want 0 0 0", k, busy, p0_ack, p1_ack);
            end
        end
    endtask

    task automatic test_in_flight;
        preload(9'h055, 16'hC3C3);
        preload(9'h066, 16'hD4D4);
        p1_req = 1; p1_we = 0; p1_addr = 9'h055;
        step();
        p0_req = 1; p0_we = 0; p0_addr = 9'h066;
        step(); step();
        n_vec++;
        if (p1_ack !== 1'b1 || p0_ack !== 1'b0 || p1_rdata !== 16'hC3C3) begin
            n_err++;
            $display("FAIL flight_p1: got a1 %b a0 %b r1 %h want 1 0 c3c3", p1_ack, p0_ack, p1_rdata);
        end
        p1_req = 0;
        step();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL flight_idle: got busy %b want 0", busy);
        end
        step();
        n_vec++;
        if (mem_addr !== 9'h066 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL flight_p0_grant: got addr %h busy %b want 066 1", mem_addr, busy);
        end
        step(); step();
        n_vec++;
        if (p0_ack !== 1'b1 || p0_rdata !== 16'hD4D4 || p1_rdata !== 16'hC3C3) begin
            n_err++;
            $display("FAIL flight_p0: got a0 %b r0 %h r1 %h want 1 d4d4 c3c3", p0_ack, p0_rdata, p1_rdata);
        end
        p0_req = 0;
        step();
    endtask

    task automatic test_reset_mid;
        p0_req = 1; p0_we = 1; p0_addr = 9'h020; p0_wdata = 16'h5555;
        step(); step();
        n_vec++;
        if (mem_write !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_strobe: got w %b want 1", mem_write);
        end
        rst = 1;
        step();
        rst = 0;
        n_vec++;
        if ({mem_write, mem_ena, busy, p0_ack, p1_ack} !== 5'b0) begin
            n_err++;
            $display("FAIL rstmid_abort: got w/e/b/a0/a1 %b want 00000", {mem_write, mem_ena, busy, p0_ack, p1_ack});
        end
        p1_req = 1; p1_we = 0; p1_addr = 9'h077;
        step();
        n_vec++;
        if (mem_addr !== 9'h020) begin
            n_err++;
            $display("FAIL rstmid_first: got addr %h want 020", mem_addr);
        end
        step(); step();
        n_vec++;
        if (p0_ack !== 1'b1 || p1_ack !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_ack: got a0 %b a1 %b want 1 0", p0_ack, p1_ack);
        end
        p0_req = 0; p1_req = 0;
        step();
    endtask

    task automatic test_req_drop;
        int acks;
        acks = 0;
        p1_req = 1; p1_we = 0; p1_addr = 9'h010;
        step();
        p1_req = 0;
        p1_addr = 9'h1FF;
        step();
        n_vec++;
        if (mem_addr !== 9'h010 || mem_read !== 1'b1) begin
            n_err++;
            $display("FAIL drop_latch: got addr %h r %b want 010 1", mem_addr, mem_read);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            if (p1_ack === 1'b1) acks++;
        end
        n_vec++;
        if (acks != 1 || p1_rdata !== 16'hBEEF || busy !== 1'b0) begin
            n_err++;
            $display("FAIL drop_ack: got acks %0d r1 %h busy %b want 1 beef 0", acks, p1_rdata, busy);
        end
    endtask

    initial begin
        test_reset();
        test_p0_read();
        test_write_then_read();
        test_contention();
        test_in_flight();
        test_reset_mid();
        test_req_drop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and sequencer for the shared 512x16 `ram`. It lets an instruction-fetch requester (port 0) and a load/store requester (port 1) share the single RAM. Arbitration between the ports is round-robin. The block generates the RAM's `ena`/`read`/`write` strobes and owns the tristate data bus. It also enforces address/data setup and hold around the RAM's write edge, because the RAM writes on the rising edge of its `write` input.

## Interface
- ADDR_W, 9, RAM word-address width
- DATA_W, 16, RAM data width
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- p0_req  input  1  port 0 request; held high until p0_ack
- p0_we  input  1  port 0 write enable (1 = write, 0 = read)
- p0_addr  input  ADDR_W  port 0 word address
- p0_wdata  input  DATA_W  port 0 write data
- p0_ack  output  1  one-cycle completion pulse for port 0
- p0_rdata  output  DATA_W  last data read by port 0
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0, for port 1
- busy  output  1  high in any state other than IDLE
- mem_addr  output  ADDR_W  to RAM `addr`
- mem_ena  output  1  to RAM `ena`
- mem_read  output  1  to RAM `read`
- mem_write  output  1  to RAM `write`
- mem_data  inout  DATA_W  to RAM `data`; driven only during write accesses

## Operation
- All outputs are registered. mem_data is driven from a registered enable and value.
- FSM states: IDLE -> SETUP -> STROBE -> RELEASE -> IDLE. Every access takes exactly 4 cycles, with no bypass.
- **IDLE**
  - Strobes and mem_ena are low; mem_data is high-Z.
  - If any req is high, arbitrate, latch the winner's id, we, addr and wdata, then go to SETUP.
- **Arbitration**
  - If only one port requests, that port wins.
  - If both request, the port that did not win last time wins.
  - last_grant resets to 1, so port 0 wins the first contention.
- **SETUP**
  - mem_addr = latched addr; mem_ena = 1.
  - On a write, mem_data is driven with the latched wdata.
  - mem_read = mem_write = 0.
- **STROBE**
  - On a read, mem_read = 1. At the end of the cycle, mem_data is captured into the winner's rdata register.
  - On a write, mem_write = 1; the RAM write occurs at this rising edge.
- **RELEASE**
  - mem_read = mem_write = 0.
  - mem_ena, mem_addr and the driven mem_data are held (write hold).
  - The winner's ack is high for this cycle only.
- **Bus ownership**
  - mem_data is never driven while mem_read = 1.
  - mem_data is driven only in SETUP/STROBE/RELEASE of a write.
- **Request rules**
  - Request fields are latched at grant. Changes after grant have no effect on the current access.
  - If req drops before ack, the access still completes and ack still pulses.
  - A req still high in the cycle after ack is a new request.
- **rdata**
  - Each port's rdata is updated only by that port's reads.
  - Writes and the other port's accesses leave it unchanged.

## Timing
- Request sampled in IDLE at edge N:
  - SETUP during cycle N+1
  - STROBE during N+2 (mem_write/mem_read rise at edge N+1)
  - RELEASE/ack during N+3
  - IDLE again at N+4
- Read data is valid on pX_rdata in the ack cycle and held afterwards.
- Sustained throughput is one access per 4 cycles. With both ports saturated, grants alternate p0, p1, p0, ...
- **Reset values:** state = IDLE; busy, mem_ena, mem_read, mem_write, p0_ack, p1_ack = 0; mem_addr = 0; mem_data = high-Z; p0_rdata = p1_rdata = 0; last_grant = 1.
- **Reset mid-access**
  - The FSM goes to IDLE at the next edge, all strobes drop, the bus is released, and no ack is issued.
  - A write already strobed may have committed.
  - last_grant is reset.

## Test plan
- Port 0 read, addr 9'h010 preloaded with 16'hBEEF, p1 idle -> mem_read high only in STROBE; p0_ack pulses 3 cycles after req is sampled; p0_rdata = 16'hBEEF; mem_data never driven.
- Port 1 write 16'h1234 to 9'h1FF, then port 0 read 9'h1FF -> mem_data stable from SETUP through RELEASE around the mem_write pulse; RAM word = 16'h1234; p0_rdata = 16'h1234; p1_rdata unchanged (0).
- p0 and p1 both request continuously from reset for 4 accesses -> grant order p0, p1, p0, p1; acks every 4 cycles, alternating; busy high except the single IDLE cycle between accesses.
- p1 read in flight while p0 requests a read -> p0 waits until IDLE, then is granted; p1_rdata holds its value while p0 completes.
- rst asserted during STROBE of a p0 write -> next cycle mem_write/mem_ena = 0, mem_data high-Z, no p0_ack; with both ports requesting afterwards, p0 wins first.
- p1_req dropped in SETUP -> access completes, p1_ack pulses once, and no second access is started.
